convclk_ffwrarb: RTL and testbench

- Write-side scheduler for one dual-clock gray-pointer FIFO.
- Shares the single FIFO write port among NREQ packet sources using round-robin arbitration at packet boundaries.
- A packet starts only when the FIFO has room for a maximum-size packet. Once granted, the packet is never interleaved with another source.
- Also sequences FIFO flush requests. Sits entirely in the FIFO write clock domain, directly in front of the write controller.

---
 rtl/convclk_pkg.sv | 5 +
 rtl/convclk_rrarb.sv | 29 ++
 rtl/convclk_ffwrarb.sv | 100 ++++++++++
 tb/tb_convclk_ffwrarb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/convclk_pkg.sv
// convclk_pkg: shared state encoding and constants for the FIFO write/read schedulers.
package convclk_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, FLUSH = 2'd2} state_t;
  localparam int STATW = 16;
endpackage

// File: rtl/convclk_rrarb.sv
// convclk_rrarb: combinational round-robin picker; the first requester after ptr wins, wrapping modulo NREQ.
module convclk_rrarb #(
  parameter int NREQ = 4,
  parameter int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx,
  output logic            any
);
  logic [IW:0] s;
  // Scanning from the farthest candidate down lets the nearest one overwrite the result.
  always_comb begin
    win = '0;
    idx = '0;
    s = '0;
    for (int k = NREQ; k >= 1; k--) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
      if (req[s[IW-1:0]]) begin
        win = '0;
        win[s[IW-1:0]] = 1'b1;
        idx = s[IW-1:0];
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/convclk_ffwrarb.sv
// convclk_ffwrarb: packet-granular round-robin write scheduler and flush sequencer for a dual-clock FIFO.
// Optional per-source beat statistics are built when CONVCLK_WRARB_STAT_EN is defined.
module convclk_ffwrarb import convclk_pkg::*; #(
  parameter int NREQ = 4,
  parameter int ADDRB = 4,
  parameter int DW = 32,
  parameter int PKTMAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*DW-1:0]  reqdat,
  input  logic [NREQ-1:0]     reqlast,
  output logic [NREQ-1:0]     reqack,
  input  logic                flushreq,
  output logic                flushack,
  output logic                fifowr,
  output logic [DW-1:0]       fifodat,
  output logic                fifoflush,
  input  logic                fifofull,
  input  logic [ADDRB:0]      wrfifolen,
  output logic [NREQ-1:0]     gnt,
  output logic                pkterr
`ifdef CONVCLK_WRARB_STAT_EN
  ,
  input  logic                statclr,
  output logic [NREQ*STATW-1:0] statcnt
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(PKTMAX + 1);
  localparam logic [ADDRB:0] DEPTH = (ADDRB+1)'(1 << ADDRB);
  localparam logic [ADDRB:0] PMAX = (ADDRB+1)'(PKTMAX);
  state_t state, state_n;
  logic [NREQ-1:0] win;
  logic [IW-1:0] widx, gidx, rr;
  logic [CW-1:0] cnt;
  logic [ADDRB:0] free;
  logic any, last, done, go;
  convclk_rrarb #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req(req),
    .ptr(rr),
    .win(win),
    .idx(widx),
    .any(any)
  );
  // Fill level lags the read side, so this under-reports space and never over-commits.
  assign free = DEPTH - wrfifolen;
  assign reqack = gnt & req & {NREQ{~fifofull}};
  assign fifowr = |reqack;
  assign last = |(gnt & reqlast);
  assign done = fifowr & (last | (cnt == CW'(PKTMAX - 1)));
  assign go = (state == IDLE) & ~flushreq & any & (free >= PMAX);
  always_comb begin
    fifodat = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) fifodat = reqdat[i*DW +: DW];
  end
  always_comb begin
    state_n = (state == FLUSH) ? IDLE :
              (state == IDLE)  ? (flushreq ? FLUSH : (go ? XFER : IDLE)) :
              (done ? IDLE : XFER);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      gidx <= '0;
      rr <= IW'(NREQ - 1);
      cnt <= '0;
      fifoflush <= 1'b0;
      flushack <= 1'b0;
      pkterr <= 1'b0;
    end else begin
      state <= state_n;
      fifoflush <= state_n == FLUSH;
      flushack <= state_n == FLUSH;
      pkterr <= done & ~last;
      cnt <= done ? '0 : cnt + CW'(fifowr);
      if (go) begin
        gnt <= win;
        gidx <= widx;
      end else if (done) begin
        gnt <= '0;
        rr <= gidx;
      end
    end
  end
`ifdef CONVCLK_WRARB_STAT_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [STATW-1:0] c;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) c <= '0;
      else if (statclr) c <= '0;
      else if (reqack[i] && !(&c)) c <= c + 1'b1;
    end
    assign statcnt[i*STATW +: STATW] = c;
  end
`endif
endmodule

// File: tb/tb_convclk_ffwrarb.sv
// tb_convclk_ffwrarb: vector table, directed packet sequences and random stimulus against a cycle reference model.
module tb_convclk_ffwrarb;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int PKTMAX = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] req, reqlast, reqack, gnt;
  logic [N*DW-1:0] reqdat;
  logic [DW-1:0] fifodat;
  logic flushreq, flushack, fifowr, fifoflush, fifofull, pkterr;
  logic [4:0] wrfifolen;
  convclk_ffwrarb #(.NREQ(N), .ADDRB(4), .DW(DW), .PKTMAX(PKTMAX)) dut (
    .clk(clk), .rst(rst), .req(req), .reqdat(reqdat), .reqlast(reqlast), .reqack(reqack),
    .flushreq(flushreq), .flushack(flushack), .fifowr(fifowr), .fifodat(fifodat),
    .fifoflush(fifoflush), .fifofull(fifofull), .wrfifolen(wrfifolen), .gnt(gnt), .pkterr(pkterr)
  );
  int nvec = 0, nerr = 0;
  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: owner index (-1 when none), flush-in-progress flag, last winner, beats taken.
  int m_own, m_rr, m_cnt;
  bit m_fl, m_perr, m_ff;
  task automatic model_reset();
    m_own = -1; m_rr = N - 1; m_cnt = 0; m_fl = 0; m_perr = 0; m_ff = 0;
  endtask
  task automatic model_adv();
    bit perr = 0;
    if (m_fl) m_fl = 0;
    else if (m_own < 0) begin
      if (flushreq) m_fl = 1;
      else if (req != 0 && 16 - int'(wrfifolen) >= PKTMAX)
        for (int k = 1; k <= N; k++)
          if (m_own < 0 && req[(m_rr + k) % N]) m_own = (m_rr + k) % N;
    end else if (req[m_own] && !fifofull) begin
      m_cnt++;
      if (reqlast[m_own] || m_cnt == PKTMAX) begin
        perr = !reqlast[m_own];
        m_rr = m_own; m_own = -1; m_cnt = 0;
      end
    end
    m_perr = perr;
    m_ff = m_fl;
  endtask
  logic [N-1:0] ack_q;
  task automatic check();
    logic [N-1:0] eg, ea;
    logic [DW-1:0] ed;
    eg = (m_own >= 0) ? N'(1) << m_own : '0;
    ea = (m_own >= 0 && req[m_own] && !fifofull) ? eg : '0;
    ed = (m_own >= 0) ? reqdat[m_own*DW +: DW] : '0;
    cmp("gnt", gnt, eg);
    cmp("reqack", reqack, ea);
    cmp("fifowr", fifowr, |ea);
    cmp("fifodat", fifodat, ed);
    cmp("pkterr", pkterr, m_perr);
    cmp("fifoflush", fifoflush, m_ff);
    cmp("flushack", flushack, m_ff);
    ack_q = reqack;
  endtask
  task automatic step();
    #1 check();
    @(posedge clk);
    if (!rst) model_adv();
    @(negedge clk);
  endtask
  // Packet sources: rem beats left, bn beats sent, plen beats per packet.
  int rem[N], bn[N], plen[N];
  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      if (ack_q[i]) begin rem[i]--; bn[i]++; end
      req[i] = rem[i] > 0;
      reqlast[i] = (plen[i] > 0) && ((bn[i] + 1) % plen[i] == 0);
      reqdat[i*DW +: DW] = {8'(i), 24'(bn[i])};
    end
    ack_q = '0;
  endtask
  task automatic sstep();
    drive_src();
    step();
  endtask
  typedef struct {
    logic [3:0] rq, lt;
    logic [4:0] ln;
    logic fu, fl;
    logic [3:0] eg, ea;
    logic ef;
  } vec_t;
  vec_t tbl[$];
  task automatic add(logic [3:0] rq, logic [3:0] lt, logic [4:0] ln, logic fu, logic fl,
                     logic [3:0] eg, logic [3:0] ea, logic ef);
    tbl.push_back('{rq, lt, ln, fu, fl, eg, ea, ef});
  endtask
  int ord[$];
  logic [N-1:0] pg, gfirst;
  int e_rr[5] = '{0, 1, 2, 3, 0};
  int e_tr[5] = '{1, 2, 3, 0, 2};
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    req = '0; reqlast = '0; reqdat = '0; flushreq = 0; fifofull = 0; wrfifolen = '0; ack_q = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; bn[i] = 0; plen[i] = 1; end
    model_reset();
    @(negedge clk);
    #1 check();
    @(negedge clk);
    rst = 0;
    // 3-beat packet, space gating, full stall, flush priority over a pending request
    add(4'b0001, 4'b0000, 5'd0,  0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0001, 4'b0000, 5'd0,  0, 0, 4'b0001, 4'b0001, 0);
    add(4'b0001, 4'b0000, 5'd1,  0, 0, 4'b0001, 4'b0001, 0);
    add(4'b0001, 4'b0001, 5'd2,  0, 0, 4'b0001, 4'b0001, 0);
    add(4'b0000, 4'b0000, 5'd3,  0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0010, 4'b0000, 5'd13, 0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0010, 4'b0000, 5'd13, 0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0010, 4'b0000, 5'd12, 0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0010, 4'b0010, 5'd12, 0, 0, 4'b0010, 4'b0010, 0);
    add(4'b0000, 4'b0000, 5'd0,  0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0100, 4'b0000, 5'd0,  0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0100, 4'b0000, 5'd0,  1, 0, 4'b0100, 4'b0000, 0);
    add(4'b0100, 4'b0100, 5'd0,  0, 0, 4'b0100, 4'b0100, 0);
    add(4'b0000, 4'b0000, 5'd0,  0, 0, 4'b0000, 4'b0000, 0);
    add(4'b1000, 4'b0000, 5'd0,  0, 1, 4'b0000, 4'b0000, 0);
    add(4'b1000, 4'b0000, 5'd0,  0, 0, 4'b0000, 4'b0000, 1);
    add(4'b1000, 4'b0000, 5'd0,  0, 0, 4'b0000, 4'b0000, 0);
    add(4'b1000, 4'b1000, 5'd0,  0, 0, 4'b1000, 4'b1000, 0);
    add(4'b0000, 4'b0000, 5'd0,  0, 0, 4'b0000, 4'b0000, 0);
    reqdat = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    foreach (tbl[v]) begin
      req = tbl[v].rq; reqlast = tbl[v].lt; wrfifolen = tbl[v].ln;
      fifofull = tbl[v].fu; flushreq = tbl[v].fl;
      #1;
      cmp("tbl_gnt", gnt, tbl[v].eg);
      cmp("tbl_ack", reqack, tbl[v].ea);
      cmp("tbl_wr", fifowr, |tbl[v].ea);
      cmp("tbl_flush", fifoflush, tbl[v].ef);
      cmp("tbl_dat", fifodat, (tbl[v].eg != 0) ? 32'hD0 + $clog2(tbl[v].eg) : 32'h0);
      step();
    end
    // Round-robin fairness: all four with 2-beat packets, source 0 has two packets
    wrfifolen = '0; fifofull = 0; flushreq = 0; ack_q = '0; pg = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 2; bn[i] = 0; plen[i] = 2; end
    rem[0] = 4;
    for (int k = 0; k < 60; k++) begin
      sstep();
      if (gnt != 0 && pg == 0) ord.push_back($clog2(gnt));
      pg = gnt;
    end
    cmp("rr_count", ord.size(), 5);
    for (int i = 0; i < 5 && i < ord.size(); i++) cmp("rr_order", ord[i], e_rr[i]);
    // Truncation: source 2 sends 6 beats without last until beat 6
    ord.delete(); pg = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 2; bn[i] = 0; plen[i] = 2; end
    rem[2] = 6; plen[2] = 6;
    begin
      int nperr = 0, perr_beats = -1;
      for (int k = 0; k < 60; k++) begin
        sstep();
        if (gnt != 0 && pg == 0) ord.push_back($clog2(gnt));
        pg = gnt;
        if (pkterr) begin nperr++; perr_beats = bn[2] + int'(ack_q[2]); end
      end
      cmp("trunc_pkterr_count", nperr, 1);
      cmp("trunc_pkterr_beat", perr_beats, 4);
      cmp("trunc_count", ord.size(), 5);
      for (int i = 0; i < 5 && i < ord.size(); i++) cmp("trunc_order", ord[i], e_tr[i]);
      cmp("trunc_src2_done", rem[2], 0);
    end
    // Flush raised mid-packet is deferred until the packet ends
    for (int i = 0; i < N; i++) begin rem[i] = 0; bn[i] = 0; plen[i] = 1; end
    rem[0] = 3; plen[0] = 3;
    begin
      int lastk = -100, flk = -1, nfl = 0;
      bit raised = 0;
      for (int k = 0; k < 30; k++) begin
        sstep();
        if (ack_q[0] && bn[0] == 2) lastk = k;
        if (fifoflush) begin nfl++; flk = k; cmp("flush_no_gnt", gnt, 0); end
        if (flushack) flushreq = 0;
        if (!raised && bn[0] == 1) begin
          raised = 1; flushreq = 1; rem[1] = 2; plen[1] = 2; bn[1] = 0;
        end
      end
      cmp("flush_count", nfl, 1);
      cmp("flush_gap", flk - lastk, 1);
      cmp("flush_src1_done", rem[1], 0);
    end
    // Asynchronous reset during beat 2
    for (int i = 0; i < N; i++) begin rem[i] = 0; bn[i] = 0; plen[i] = 1; end
    rem[0] = 4; plen[0] = 4;
    begin
      bit hit = 0;
      for (int k = 0; k < 20 && !hit; k++) begin
        drive_src();
        if (gnt[0] && bn[0] == 1) hit = 1;
        else step();
      end
      cmp("rst_reach_beat2", hit, 1);
      #2 cmp("rst_pre_wr", fifowr, 1);
      #1 rst = 1;
      #1;
      cmp("rst_gnt", gnt, 0);
      cmp("rst_wr", fifowr, 0);
      cmp("rst_ack", reqack, 0);
      model_reset();
      ack_q = '0;
      rem[1] = 2; plen[1] = 2; bn[1] = 0;
      @(negedge clk);
      rst = 0;
      gfirst = '0;
      for (int k = 0; k < 10; k++) begin
        sstep();
        if (gnt != 0 && gfirst == 0) gfirst = gnt;
      end
      cmp("rst_first_gnt", gfirst, 4'b0001);
      for (int k = 0; k < 20; k++) sstep();
      cmp("rst_src0_done", rem[0], 0);
      cmp("rst_src1_done", rem[1], 0);
    end
    // Random stimulus against the reference model
    for (int k = 0; k < 600; k++) begin
      req = 4'($urandom);
      reqlast = 4'($urandom) & 4'($urandom);
      reqdat = {$urandom, $urandom, $urandom, $urandom};
      wrfifolen = 5'($urandom_range(16, 0));
      fifofull = $urandom_range(7, 0) == 0;
      flushreq = $urandom_range(15, 0) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
